// File: rtl/reg_file.sv
// reg_file: two-read, one-write register file feeding the ALU operands.
//   Register 0 is hardwired to zero. Writes commit on the rising clock edge.
//   With BYPASS=1, a read whose address matches an active write returns the
//   write data in the same cycle. A synchronous reset clears every entry.
//
// Parameters:
//   DATA_W - register and port data width
//   ADDR_W - address width; depth is 2**ADDR_W
//   BYPASS - 1: reads see same-cycle write data; 0: reads see stored data only
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   rst    - synchronous active-high reset; clears the array, beats any write
//   raddr1 - read port 1 address (ALU data1)
//   raddr2 - read port 2 address (ALU data2)
//   rdata1 - read port 1 data, combinational
//   rdata2 - read port 2 data, combinational
//   we     - write enable
//   waddr  - write address (writes to 0 are dropped)
//   wdata  - write data
module reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_en;
    logic              byp_en;

    // A write to entry 0 is dropped, so entry 0 stays at its reset value.
    assign wr_en  = we && (waddr != '0);

    // Bypass is suppressed during reset so reads show the stored contents.
    assign byp_en = (BYPASS != 0) && we && !rst;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (byp_en && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = mem_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (byp_en && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = mem_q[raddr2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
//   Two instances share all inputs: dut_b (BYPASS=1) and dut_n (BYPASS=0),
//   so same-cycle write behaviour of both variants is compared side by side.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rdata1_b;
    logic [31:0] rdata2_b;
    logic [31:0] rdata1_n;
    logic [31:0] rdata2_n;

    int unsigned errors = 0;
    int unsigned checks = 0;

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1_b),
        .rdata2 (rdata2_b),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_n (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1_n),
        .rdata2 (rdata2_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move off the edge before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e1;
        logic [31:0] e2;

        rst = 1'b1;
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        raddr1 = 5'd5;
        raddr2 = 5'd9;

        // Reset state
        step();
        rst = 1'b0;
        #1;
        chk("rst_init_p1", rdata1_b, 32'h0);
        chk("rst_init_p2", rdata2_b, 32'h0);
        chk("rst_init_nb", rdata1_n, 32'h0);

        // Reset clears a previously written entry
        wr(5'd5, 32'hDEADBEEF);
        raddr1 = 5'd5;
        raddr2 = 5'd5;
        #1;
        chk("pre_rst_r5", rdata1_b, 32'hDEADBEEF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_clear_p1", rdata1_b, 32'h0);
        chk("rst_clear_p2", rdata2_b, 32'h0);

        // Reset beats a concurrent write; bypass is suppressed during reset
        wr(5'd5, 32'hDEADBEEF);
        rst = 1'b1;
        we = 1'b1;
        waddr = 5'd5;
        wdata = 32'h12345678;
        #1;
        chk("rst_nobyp_p1", rdata1_b, 32'hDEADBEEF);
        step();
        rst = 1'b0;
        we = 1'b0;
        #1;
        chk("rst_vs_wr_p1", rdata1_b, 32'h0);
        chk("rst_vs_wr_p2", rdata2_b, 32'h0);
        chk("rst_vs_wr_nb", rdata1_n, 32'h0);

        // r0 hardwired to zero, including through the bypass
        we = 1'b1;
        waddr = 5'd0;
        wdata = 32'hFFFFFFFF;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        #1;
        chk("r0_wrcyc_p1", rdata1_b, 32'h0);
        chk("r0_wrcyc_p2", rdata2_b, 32'h0);
        step();
        we = 1'b0;
        #1;
        chk("r0_after_p1", rdata1_b, 32'h0);
        chk("r0_after_nb", rdata1_n, 32'h0);

        // Basic dual-port write/read and the ALU view of the operands
        wr(5'd1, 32'h0000000F);
        wr(5'd2, 32'h00000007);
        raddr1 = 5'd1;
        raddr2 = 5'd2;
        #1;
        chk("basic_p1", rdata1_b, 32'h0000000F);
        chk("basic_p2", rdata2_b, 32'h00000007);
        a = rdata1_b;
        b = rdata2_b;
        chk("alu_add", a + b, 32'h00000016);
        chk("alu_sub", a - b, 32'h00000008);

        // Bypass on both ports vs. stored-only behaviour
        wr(5'd3, 32'h11111111);
        we = 1'b1;
        waddr = 5'd3;
        wdata = 32'h22222222;
        raddr1 = 5'd3;
        raddr2 = 5'd3;
        #1;
        chk("byp1_p1", rdata1_b, 32'h22222222);
        chk("byp1_p2", rdata2_b, 32'h22222222);
        chk("byp0_p1_pre", rdata1_n, 32'h11111111);
        chk("byp0_p2_pre", rdata2_n, 32'h11111111);
        raddr2 = 5'd2;
        #1;
        chk("byp_nomatch_p2", rdata2_b, 32'h00000007);
        step();
        we = 1'b0;
        raddr2 = 5'd3;
        #1;
        chk("byp0_p1_post", rdata1_n, 32'h22222222);
        chk("byp0_p2_post", rdata2_n, 32'h22222222);
        chk("byp1_p1_post", rdata1_b, 32'h22222222);

        // Write disabled
        wr(5'd4, 32'h55555555);
        we = 1'b0;
        waddr = 5'd4;
        wdata = 32'hAAAAAAAA;
        raddr1 = 5'd4;
        raddr2 = 5'd4;
        #1;
        chk("wedis_pre_p1", rdata1_b, 32'h55555555);
        chk("wedis_pre_p2", rdata2_b, 32'h55555555);
        step();
        chk("wedis_post_p1", rdata1_b, 32'h55555555);
        chk("wedis_post_p2", rdata2_n, 32'h55555555);

        // Full sweep: distinct pattern per entry, read pairwise from both ends
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            e1 = 32'(i) * 32'h01010101;
            e2 = 32'(31 - i) * 32'h01010101;
            #1;
            chk($sformatf("sweep_p1_r%0d", i), rdata1_b, e1);
            chk($sformatf("sweep_p2_r%0d", 31 - i), rdata2_b, e2);
            chk($sformatf("sweep_nb_r%0d", i), rdata1_n, e1);
        end

        // Mid-sequence reset with a concurrent write clears everything
        rst = 1'b1;
        we = 1'b1;
        waddr = 5'd7;
        wdata = 32'hCAFEF00D;
        step();
        rst = 1'b0;
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            chk($sformatf("midrst_p1_r%0d", i), rdata1_b, 32'h0);
            chk($sformatf("midrst_p2_r%0d", 31 - i), rdata2_n, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file.md
# reg_file

Two-read, one-write 32 x 32-bit register file that sits directly upstream of the ALU and supplies its `data1`/`data2` operands. Register 0 is hardwired to zero. Writes commit on the rising clock edge. An optional write-through bypass lets an operand read see same-cycle write data. Synchronous reset clears the whole array.

## Interface
- `DATA_W`, 32, register and port data width
- `ADDR_W`, 5, address width; depth is 2**ADDR_W (32)
- `BYPASS`, 1, 1 = read ports return same-cycle write data on address match; 0 = read ports return stored contents only

Ports:
- `clk` input 1: single clock, all state updates on rising edge
- `rst` input 1: synchronous, active-high reset
- `raddr1` input ADDR_W: read port 1 address (drives ALU `data1`)
- `raddr2` input ADDR_W: read port 2 address (drives ALU `data2`)
- `rdata1` output DATA_W: read port 1 data, combinational from `raddr1`
- `rdata2` output DATA_W: read port 2 data, combinational from `raddr2`
- `we` input 1: write enable
- `waddr` input ADDR_W: write address
- `wdata` input DATA_W: write data

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits. Entry 0 is never written and always reads 0.
- Write: on a rising `clk` with `rst`=0, `we`=1 and `waddr`!=0, `mem[waddr]` <= `wdata`.
  - `we`=1 with `waddr`=0 is silently dropped. No state change, no error.
- Read, per port n, evaluated combinationally every cycle, in priority order:
  1. `raddrn`=0 -> 0.
  2. `BYPASS`=1, `we`=1, `rst`=0 and `raddrn`=`waddr` -> `wdata`.
  3. Otherwise -> `mem[raddrn]`.
- Both ports are independent. Both may read the same address, and both may hit the bypass at once.
- Reset: with `rst`=1 at a rising edge, all entries <= 0. Any write presented in that cycle is discarded: reset beats write.
  - While `rst`=1, the bypass is suppressed, so reads return stored contents.
  - The first cycle after reset deasserts, every read returns 0.
- Reset asserted mid-sequence discards any pending/concurrent write and clears every entry, including ones written earlier. No partial state survives.
- Out-of-range addresses cannot occur: the address width exactly covers the depth.

## Timing
- Read latency: 0 cycles. `rdata1`/`rdata2` are combinational functions of the addresses, the array and (when `BYPASS`=1) `we`/`waddr`/`wdata`.
- Write latency: 1 edge. Data written at edge k is visible from stored contents immediately after edge k.
- With `BYPASS`=1, a read of `waddr` in the same cycle as the write already returns `wdata`. This is the effective write-before-read behaviour the single-cycle datapath requires.
- With `BYPASS`=0, a same-cycle read returns the old value, and the new value appears after the edge.
- Output reset values: `rdata1`=`rdata2`=0 for every address from the edge where `rst` is sampled high until the first committed write.
- No multi-cycle paths and no handshakes. A write is accepted every cycle `we`=1.

## Test plan
- Reset clear:
  - Stimulus: write 0xDEADBEEF to r5, then assert `rst` for 1 cycle, then read r5 on both ports.
  - Required: `rdata1`=`rdata2`=0x00000000.
  - Stimulus: repeat with `rst` and `we`=1, `waddr`=5, `wdata`=0x12345678 in the same cycle.
  - Required: r5 still reads 0.
- r0 hardwired:
  - Stimulus: `we`=1, `waddr`=0, `wdata`=0xFFFFFFFF, then read `raddr1`=0, with `BYPASS`=1.
  - Required: `rdata1`=0 in the write cycle and in all later cycles.
- Basic write/read, dual port:
  - Stimulus: write r1=0x0000000F and r2=0x00000007 on consecutive cycles, then `raddr1`=1, `raddr2`=2.
  - Required: `rdata1`=0x0000000F, `rdata2`=0x00000007.
  - Also required: feeding these to the ALU as add gives 0x16, and as subtract gives 0x8.
- Bypass:
  - Stimulus: `BYPASS`=1, r3 holds 0x11111111; in one cycle present `we`=1, `waddr`=3, `wdata`=0x22222222 with `raddr1`=`raddr2`=3.
  - Required: both outputs = 0x22222222 before the edge.
  - Stimulus: repeat with `BYPASS`=0.
  - Required: 0x11111111 before the edge and 0x22222222 after it.
- Write disabled:
  - Stimulus: `we`=0, `waddr`=4, `wdata`=0xAAAAAAAA with r4=0x55555555.
  - Required: r4 reads 0x55555555 on both ports before and after the edge.
- Full sweep:
  - Stimulus: write r(i) = i*0x01010101 for i=1..31, then read all 32 addresses pairwise on both ports.
  - Required: r0=0, r(i)=i*0x01010101 exactly, and no aliasing between entries.
